// File: rtl/icache_dm_if.sv
// Fetch-side lookup signals plus the refill burst bus of the direct-mapped I-cache.
// slave = the cache itself; master = the fetch pipeline and memory side that drive it.
interface icache_dm_if;
  logic [31:0] i_pc;
  logic        i_valid;
  logic        flush_BR;
  logic [31:0] o_IR1;
  logic [31:0] o_IR2;
  logic        o_hit;
  logic        stall_ICache;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic [31:0] ret_data;
  logic        ret_last;

  modport slave (
    input  i_pc, i_valid, flush_BR, rd_rdy, ret_valid, ret_data, ret_last,
    output o_IR1, o_IR2, o_hit, stall_ICache, rd_req, rd_addr
  );

  modport master (
    output i_pc, i_valid, flush_BR, rd_rdy, ret_valid, ret_data, ret_last,
    input  o_IR1, o_IR2, o_hit, stall_ICache, rd_req, rd_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped blocking instruction cache: returns the (PC, PC+4) word pair one cycle
// after lookup, refilling one or two lines over a burst bus on a miss.
module icache_dm #(
  parameter int INDEX_BITS = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  icache_dm_if.slave bus
);
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int TAG_BITS  = 32 - INDEX_BITS - OFF_BITS;
  localparam int NLINES    = 1 << INDEX_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, REPLAY} state_t;

  state_t                state_q, state_d;
  logic [31:0]           s_pc_q, s_pc_d;
  logic                  s_valid_q, s_valid_d;
  logic                  abort_q, abort_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic [31:0]           rd_addr_q, rd_addr_d;
  logic [31:0]           ir1_q, ir2_q;

  logic                  miss_idle, stall, load, hit, hit_a, hit_b, pair_hit;
  logic [31:0]           rd_pc, s_pc4, miss_addr, ir1_sel, ir2_sel, ir1_out, ir2_out;
  logic [INDEX_BITS-1:0] idx_a, idx_b, fill_idx;
  logic [TAG_BITS-1:0]   fill_tag, tag_a_q, tag_b_q;
  logic [WORD_BITS-1:0]  s_word;
  logic                  fill_we, fill_done;
  logic [NLINES-1:0]     valid_q;
  logic                  vld_a_q, vld_b_q;
  logic [31:0]           word_a [LINE_WORDS];
  logic [31:0]           word_b [LINE_WORDS];
  logic [TAG_BITS-1:0]   tag_mem [NLINES];
  logic                  unused_bits;

  // Arrays are addressed by the incoming PC when a new lookup is accepted, otherwise by
  // the held PC, so a REPLAY cycle re-reads the freshly installed line.
  assign rd_pc = load ? bus.i_pc : s_pc_q;
  assign idx_a = rd_pc[OFF_BITS +: INDEX_BITS];
  assign idx_b = (rd_pc[2 +: WORD_BITS] == LAST_WORD) ? idx_a + INDEX_BITS'(1) : idx_a;

  assign fill_we   = (state_q == REFILL) && bus.ret_valid;
  assign fill_done = fill_we && bus.ret_last;
  assign fill_idx  = rd_addr_q[OFF_BITS +: INDEX_BITS];
  assign fill_tag  = rd_addr_q[31 -: TAG_BITS];

  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] mem [NLINES];
      logic [31:0] rd_a_q, rd_b_q;
      always_ff @(posedge clk) begin
        if (fill_we && cnt_q == WORD_BITS'(gi)) begin
          mem[fill_idx] <= bus.ret_data;
        end
        rd_a_q <= mem[idx_a];
        rd_b_q <= mem[idx_b];
      end
      assign word_a[gi] = rd_a_q;
      assign word_b[gi] = rd_b_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx] <= fill_tag;
    end
    tag_a_q <= tag_mem[idx_a];
    tag_b_q <= tag_mem[idx_b];
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      valid_q <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
    end else begin
      if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
      end
      vld_a_q <= valid_q[idx_a];
      vld_b_q <= valid_q[idx_b];
    end
  end

  // Port B holds the same line as port A unless PC+4 crosses into the next line.
  assign s_pc4     = s_pc_q + 32'd4;
  assign s_word    = s_pc_q[2 +: WORD_BITS];
  assign hit_a     = vld_a_q && (tag_a_q == s_pc_q[31 -: TAG_BITS]);
  assign hit_b     = vld_b_q && (tag_b_q == s_pc4[31 -: TAG_BITS]);
  assign pair_hit  = hit_a && hit_b;
  assign ir1_sel   = word_a[s_word];
  assign ir2_sel   = (s_word == LAST_WORD) ? word_b[0] : word_a[s_word + WORD_BITS'(1)];
  assign miss_addr = hit_a ? {s_pc4[31:OFF_BITS], OFF_BITS'(0)}
                           : {s_pc_q[31:OFF_BITS], OFF_BITS'(0)};

  assign miss_idle = (state_q == IDLE) && s_valid_q && !pair_hit;
  assign stall     = (state_q != IDLE) || (miss_idle && !bus.flush_BR);
  assign load      = !stall && !bus.flush_BR;
  assign hit       = (state_q == IDLE) && s_valid_q && pair_hit;
  assign ir1_out   = hit ? ir1_sel : ir1_q;
  assign ir2_out   = hit ? ir2_sel : ir2_q;

  assign bus.o_hit        = hit;
  assign bus.o_IR1        = ir1_out;
  assign bus.o_IR2        = ir2_out;
  assign bus.stall_ICache = stall;
  assign bus.rd_req       = (state_q == MISS_REQ) && !bus.flush_BR;
  assign bus.rd_addr      = rd_addr_q;

  assign unused_bits = ^{rd_pc[1:0], rd_pc[31:OFF_BITS+INDEX_BITS], s_pc_q[1:0],
                         s_pc4[OFF_BITS-1:0]};

  always_comb begin
    state_d   = state_q;
    s_pc_d    = s_pc_q;
    s_valid_d = s_valid_q;
    abort_d   = abort_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    if (load) begin
      s_pc_d    = bus.i_pc;
      s_valid_d = bus.i_valid;
    end
    case (state_q)
      IDLE: begin
        if (bus.flush_BR) begin
          s_valid_d = 1'b0;
        end else if (miss_idle) begin
          state_d   = MISS_REQ;
          rd_addr_d = miss_addr;
        end
      end
      MISS_REQ: begin
        if (bus.flush_BR) begin
          state_d   = IDLE;
          s_valid_d = 1'b0;
        end else if (bus.rd_rdy) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        // A flushed burst still runs to completion and installs its line.
        if (bus.flush_BR) begin
          abort_d = 1'b1;
        end
        if (bus.ret_valid) begin
          cnt_d = cnt_q + WORD_BITS'(1);
          if (bus.ret_last) begin
            if (abort_q || bus.flush_BR) begin
              state_d   = IDLE;
              s_valid_d = 1'b0;
              abort_d   = 1'b0;
            end else begin
              state_d = REPLAY;
            end
          end
        end
      end
      REPLAY: begin
        state_d = IDLE;
        if (bus.flush_BR) begin
          s_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= IDLE;
      s_pc_q    <= '0;
      s_valid_q <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      ir1_q     <= '0;
      ir2_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_pc_q    <= s_pc_d;
      s_valid_q <= s_valid_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      ir1_q     <= ir1_out;
      ir2_q     <= ir2_out;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: table of hit vectors plus hand-written miss, refill,
// flush and reset sequences against a scripted burst-bus responder.
module tb_icache_dm;
  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  icache_dm_if bus();

  icache_dm #(.INDEX_BITS(8), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        hit;
    logic [31:0] ir1;
    logic [31:0] ir2;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Presents one lookup for a single cycle; returns at the negedge of the result cycle.
  task automatic lookup(input logic [31:0] pc);
    bus.i_pc    = pc;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic serve_refill(input logic [31:0] exp_addr, input logic [127:0] beats,
                              input int flush_beat, input int gap_beat, input int rdy_delay);
    int n = 0;
    @(negedge clk);
    while (!bus.rd_req && n < 20) begin
      chk1("stall_wait", bus.stall_ICache, 1'b1);
      @(negedge clk);
      n++;
    end
    chk1("rd_req", bus.rd_req, 1'b1);
    chk("rd_addr", bus.rd_addr, exp_addr);
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      chk1("rd_req_hold", bus.rd_req, 1'b1);
      chk("rd_addr_hold", bus.rd_addr, exp_addr);
    end
    bus.rd_rdy = 1'b1;
    @(negedge clk);
    bus.rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == gap_beat) begin
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b1;
        bus.ret_data  = 32'hDEAD_BEEF;
        bus.flush_BR  = 1'b0;
        @(negedge clk);
      end
      bus.ret_valid = 1'b1;
      bus.ret_data  = beats[32*b +: 32];
      bus.ret_last  = (b == 3);
      bus.flush_BR  = (b == flush_beat);
      chk1("refill_stall", bus.stall_ICache, 1'b1);
      chk1("refill_hit", bus.o_hit, 1'b0);
      chk1("refill_req", bus.rd_req, 1'b0);
      @(negedge clk);
    end
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    bus.flush_BR  = 1'b0;
    $display("refill %h done (flush_beat=%0d gap_beat=%0d)", exp_addr, flush_beat, gap_beat);
  endtask

  // Called in the REPLAY cycle; checks it, then the hit in the following cycle.
  task automatic expect_replay_hit(input logic [31:0] ir1, input logic [31:0] ir2);
    chk1("replay_stall", bus.stall_ICache, 1'b1);
    chk1("replay_hit", bus.o_hit, 1'b0);
    @(negedge clk);
    $display("replay hit=%b ir1=%h ir2=%h", bus.o_hit, bus.o_IR1, bus.o_IR2);
    chk1("post_hit", bus.o_hit, 1'b1);
    chk("post_ir1", bus.o_IR1, ir1);
    chk("post_ir2", bus.o_IR2, ir2);
    chk1("post_stall", bus.stall_ICache, 1'b0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      bus.i_pc     = vecs[k].pc;
      bus.i_valid  = vecs[k].valid;
      bus.flush_BR = vecs[k].flush;
      @(negedge clk);
      $display("vec %0d pc=%h v=%b f=%b -> hit=%b ir1=%h ir2=%h", k, vecs[k].pc,
               vecs[k].valid, vecs[k].flush, bus.o_hit, bus.o_IR1, bus.o_IR2);
      chk1("vec_hit", bus.o_hit, vecs[k].hit);
      chk("vec_ir1", bus.o_IR1, vecs[k].ir1);
      chk("vec_ir2", bus.o_IR2, vecs[k].ir2);
      chk1("vec_rd_req", bus.rd_req, 1'b0);
      chk1("vec_stall", bus.stall_ICache, 1'b0);
    end
    bus.i_valid  = 1'b0;
    bus.flush_BR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1C00_0008, 1'b1, 1'b0, 1'b1, 32'h33, 32'h44};
    vecs[1] = '{32'h1C00_0004, 1'b1, 1'b0, 1'b1, 32'h22, 32'h33};
    vecs[2] = '{32'h1C00_0000, 1'b0, 1'b0, 1'b0, 32'h22, 32'h33};
    vecs[3] = '{32'h1C00_0000, 1'b1, 1'b1, 1'b0, 32'h22, 32'h33};
    vecs[4] = '{32'h1C00_0003, 1'b1, 1'b0, 1'b1, 32'h11, 32'h22};
    vecs[5] = '{32'h1C00_0010, 1'b1, 1'b0, 1'b1, 32'hA0, 32'hA1};
    vecs[6] = '{32'h1C00_0018, 1'b1, 1'b0, 1'b1, 32'hA2, 32'hA3};
    vecs[7] = '{32'h1C00_000C, 1'b1, 1'b0, 1'b1, 32'h44, 32'hA0};
    vecs[8] = '{32'h1C00_100C, 1'b1, 1'b1, 1'b0, 32'hB3, 32'hC0};

    bus.i_pc = '0; bus.i_valid = 1'b0; bus.flush_BR = 1'b0; bus.rd_rdy = 1'b0;
    bus.ret_valid = 1'b0; bus.ret_data = '0; bus.ret_last = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_hit", bus.o_hit, 1'b0);
    chk1("rst_stall", bus.stall_ICache, 1'b0);
    chk1("rst_rd_req", bus.rd_req, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 32'h0);
    chk("rst_ir1", bus.o_IR1, 32'h0);
    chk("rst_ir2", bus.o_IR2, 32'h0);
    rstn = 1'b0;
    @(negedge clk);

    // Cold miss with a slow rd_rdy and an idle beat inside the burst.
    lookup(32'h1C00_0000);
    chk1("cold_stall", bus.stall_ICache, 1'b1);
    chk1("cold_hit", bus.o_hit, 1'b0);
    serve_refill(32'h1C00_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 2, 2);
    expect_replay_hit(32'h11, 32'h22);
    run_vecs(0, 4);

    // Line crossing: only the PC+4 line is missing.
    lookup(32'h1C00_000C);
    serve_refill(32'h1C00_0010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, -1, 0);
    expect_replay_hit(32'h44, 32'hA0);
    run_vecs(5, 7);

    // Double miss: PC line first, then PC+4 line.
    lookup(32'h1C00_100C);
    serve_refill(32'h1C00_1000, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1, -1, 1);
    serve_refill(32'h1C00_1010, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1, 1, 0);
    expect_replay_hit(32'hB3, 32'hC0);
    run_vecs(8, 8);

    // Top index: PC+4 wraps to index 0, which already holds 0x1C001000.
    lookup(32'h1C00_0FFC);
    serve_refill(32'h1C00_0FF0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, -1, -1, 0);
    expect_replay_hit(32'hD3, 32'hB0);

    // Flush during beat 2: burst drains, no hit, line still installed.
    lookup(32'h1C00_0000);
    serve_refill(32'h1C00_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 2, -1, 0);
    chk1("flush_stall", bus.stall_ICache, 1'b0);
    chk1("flush_hit", bus.o_hit, 1'b0);
    chk("flush_ir1_hold", bus.o_IR1, 32'hD3);
    @(negedge clk);
    chk1("flush_hit2", bus.o_hit, 1'b0);
    lookup(32'h1C00_0004);
    $display("after flush lookup hit=%b ir1=%h ir2=%h", bus.o_hit, bus.o_IR1, bus.o_IR2);
    chk1("aflush_hit", bus.o_hit, 1'b1);
    chk("aflush_ir1", bus.o_IR1, 32'h22);
    chk("aflush_ir2", bus.o_IR2, 32'h33);
    chk1("aflush_rd_req", bus.rd_req, 1'b0);

    // Reset asserted during beat 1 of a refill.
    lookup(32'h1C00_2000);
    begin
      int n = 0;
      while (!bus.rd_req && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk1("rmid_req", bus.rd_req, 1'b1);
    chk("rmid_addr", bus.rd_addr, 32'h1C00_2000);
    bus.rd_rdy = 1'b1;
    @(negedge clk);
    bus.rd_rdy = 1'b0;
    bus.ret_valid = 1'b1;
    bus.ret_data  = 32'h55;
    @(negedge clk);
    bus.ret_data = 32'h66;
    rstn = 1'b1;
    #1;
    $display("reset mid-refill: rd_req=%b stall=%b hit=%b", bus.rd_req, bus.stall_ICache, bus.o_hit);
    chk1("rmid_rd_req", bus.rd_req, 1'b0);
    chk1("rmid_stall", bus.stall_ICache, 1'b0);
    chk1("rmid_hit", bus.o_hit, 1'b0);
    bus.ret_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    lookup(32'h1C00_0000);
    chk1("rmid_miss_stall", bus.stall_ICache, 1'b1);
    chk("rmid_ir1_zero", bus.o_IR1, 32'h0);
    serve_refill(32'h1C00_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1, 0);
    expect_replay_hit(32'h11, 32'h22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
